i2c_master_arbiter: RTL

//  Shares a single I2C master (the i2c_master side of memorysubsystem) among NREQ requesters.

---
 rtl/i2c_master_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one I2C master among NREQ requesters; grant/m_* one cycle after request, done one cycle after m_done.
// Optional WAIT watchdog enabled by defining I2C_ARB_TIMEOUT_EN (times out after TIMEOUT_CYCLES wait cycles).
module i2c_master_arbiter #(
  parameter int NREQ           = 4,
  parameter int DATAWIDTH      = 8,
  parameter int ADDRWIDTH      = 7,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NREQ-1:0]           req_i,
  input  logic [NREQ-1:0]           req_write_i,
  input  logic [NREQ-1:0]           req_read_i,
  input  logic [NREQ*ADDRWIDTH-1:0] req_addr_i,
  input  logic [NREQ*DATAWIDTH-1:0] req_data_i,
  output logic [NREQ-1:0]           gnt_o,
  output logic [NREQ-1:0]           done_o,
  output logic [NREQ-1:0]           nack_o,
  output logic                      m_enable_o,
  output logic                      m_write_o,
  output logic                      m_read_o,
  output logic [ADDRWIDTH-1:0]      m_addr_o,
  output logic [DATAWIDTH-1:0]      m_data_in_o,
  input  logic                      m_ack_i,
  input  logic                      m_done_i
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e               state_q;
  logic [PW-1:0]        ptr_q;
  logic [NREQ-1:0]      gnt_q, done_q, nack_q;
  logic                 m_enable_q, m_write_q, m_read_q;
  logic [ADDRWIDTH-1:0] m_addr_q;
  logic [DATAWIDTH-1:0] m_data_q;

  logic                 win_vld_d;
  logic [PW-1:0]        win_d, idx_d;
  logic [NREQ-1:0]      gnt_d;
  logic                 wr_d, rd_d;
  logic [ADDRWIDTH-1:0] addr_d;
  logic [DATAWIDTH-1:0] data_d;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
`endif

  // Scan from farthest to nearest offset so the requester just after ptr_q wins.
  always_comb begin
    win_vld_d = 1'b0;
    win_d     = '0;
    idx_d     = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx_d = PW'((int'(ptr_q) + i) % NREQ);
      if (req_i[idx_d]) begin
        win_vld_d = 1'b1;
        win_d     = idx_d;
      end
    end
    gnt_d        = '0;
    gnt_d[win_d] = 1'b1;
    wr_d   = req_write_i[win_d];
    rd_d   = req_read_i[win_d] & ~req_write_i[win_d];
    addr_d = req_addr_i[int'(win_d)*ADDRWIDTH +: ADDRWIDTH];
    data_d = req_data_i[int'(win_d)*DATAWIDTH +: DATAWIDTH];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      ptr_q      <= PW'(NREQ - 1);
      gnt_q      <= '0;
      done_q     <= '0;
      nack_q     <= '0;
      m_enable_q <= 1'b0;
      m_write_q  <= 1'b0;
      m_read_q   <= 1'b0;
      m_addr_q   <= '0;
      m_data_q   <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_vld_d) begin
            gnt_q     <= gnt_d;
            ptr_q     <= win_d;
            m_write_q <= wr_d;
            m_read_q  <= rd_d;
            m_addr_q  <= addr_d;
            m_data_q  <= data_d;
            if (wr_d | rd_d) begin
              m_enable_q <= 1'b1;
              state_q    <= S_ISSUE;
            end else begin
              state_q <= S_RESP;
            end
          end
        end
        S_ISSUE: begin
          m_enable_q <= 1'b0;
          state_q    <= S_WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
          cnt_q      <= '0;
`endif
        end
        S_WAIT: begin
          if (m_done_i) begin
            done_q  <= gnt_q;
            nack_q  <= m_ack_i ? '0 : gnt_q;
            state_q <= S_RESP;
          end
`ifdef I2C_ARB_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            done_q  <= gnt_q;
            nack_q  <= gnt_q;
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        S_RESP: begin
          // An invalid command arrives here with done still clear: spend one cycle, then pulse.
          if (done_q == '0) begin
            done_q <= gnt_q;
            nack_q <= gnt_q;
          end else begin
            done_q  <= '0;
            nack_q  <= '0;
            gnt_q   <= '0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign nack_o      = nack_q;
  assign m_enable_o  = m_enable_q;
  assign m_write_o   = m_write_q;
  assign m_read_o    = m_read_q;
  assign m_addr_o    = m_addr_q;
  assign m_data_in_o = m_data_q;

endmodule
